// File: rtl/alu_in_arb_mux_pkg.sv
// Shared arbitration-mode constants and channel-index width helper for the ALU operand selectors.
package alu_in_arb_mux_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    // A single channel still needs a 1-bit index so out_ch is never zero-width.
    function automatic int ch_w_f(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/alu_in_arb_mux_rr_grant.sv
// Combinational one-hot grant: lowest requester (fixed) or first requester at/after ptr with wrap (round-robin).
module rr_grant
    import alu_in_arb_mux_pkg::*;
#(
    parameter  int N_CH = 2,
    localparam int CH_W = ch_w_f(N_CH)
) (
    input  logic [N_CH-1:0] req,
    input  logic [CH_W-1:0] ptr,
    input  logic            mode,
    output logic [N_CH-1:0] gnt,
    output logic [CH_W-1:0] idx,
    output logic            any
);

    int   base;
    logic found;

    // Two upward passes: channels at/after base first, then the wrapped-around ones below it.
    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        base  = (mode == MODE_RR) ? int'(ptr) : 0;
        for (int i = 0; i < N_CH; i++) begin
            if (!found && req[i] && (i >= base)) begin
                found  = 1'b1;
                gnt[i] = 1'b1;
                idx    = CH_W'(i);
            end
        end
        for (int i = 0; i < N_CH; i++) begin
            if (!found && req[i] && (i < base)) begin
                found  = 1'b1;
                gnt[i] = 1'b1;
                idx    = CH_W'(i);
            end
        end
        any = |req;
    end

endmodule

// File: rtl/alu_in_arb_mux.sv
// Registered N-to-1 operand selector with valid/ready per channel and fixed or round-robin arbitration.
// One-cycle latency; a held beat with out_ready low stalls every input.
module alu_in_arb_mux
    import alu_in_arb_mux_pkg::*;
#(
    parameter  int WIDTH = 6,
    parameter  int N_CH  = 2,
    localparam int CH_W  = ch_w_f(N_CH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  mode,
    input  logic [N_CH*WIDTH-1:0] in_data,
    input  logic [N_CH-1:0]       in_valid,
    output logic [N_CH-1:0]       in_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic [CH_W-1:0]       out_ch,
    output logic                  out_valid,
    input  logic                  out_ready
);

    logic [N_CH-1:0]  gnt;
    logic [CH_W-1:0]  g_idx;
    logic             g_any;
    logic             load;
    logic [WIDTH-1:0] sel_data;

    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [CH_W-1:0]  out_ch_q, out_ch_d;
    logic             out_valid_q, out_valid_d;
    logic [CH_W-1:0]  ptr_q, ptr_d;

    rr_grant #(.N_CH(N_CH)) u_grant (
        .req  (in_valid),
        .ptr  (ptr_q),
        .mode (mode),
        .gnt  (gnt),
        .idx  (g_idx),
        .any  (g_any)
    );

    assign load     = (!out_valid_q || out_ready) && g_any;
    // Gate with rst_n so no upstream beat is consumed while reset is held.
    assign in_ready = (load && rst_n) ? gnt : '0;

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (gnt[i]) begin
                sel_data = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        out_valid_d = out_valid_q;
        ptr_d       = ptr_q;
        if (load) begin
            out_data_d  = sel_data;
            out_ch_d    = g_idx;
            out_valid_d = 1'b1;
            if (mode == MODE_RR) begin
                ptr_d = (g_idx == CH_W'(N_CH - 1)) ? '0 : g_idx + CH_W'(1);
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_q  <= '0;
            out_ch_q    <= '0;
            out_valid_q <= 1'b0;
            ptr_q       <= '0;
        end else begin
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            out_valid_q <= out_valid_d;
            ptr_q       <= ptr_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;
    assign out_valid = out_valid_q;

endmodule
